bitwise_gates: RTL and testbench



---
 rtl/bitwise_gates.sv | 69 ++++++
 tb/tb_bitwise_gates.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bitwise_gates.sv
// rtl/bitwise_gates.sv - registered WIDTH-bit AND/OR/XOR unit with reduction flags
module bitwise_gates #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] bitwise_and,
  output logic [WIDTH-1:0] bitwise_or,
  output logic [WIDTH-1:0] bitwise_xor,
  output logic             out_valid,
  output logic             and_zero,
  output logic             xor_parity
);

  logic [WIDTH-1:0] and_q, and_d;
  logic [WIDTH-1:0] or_q, or_d;
  logic [WIDTH-1:0] xor_q, xor_d;
  logic             valid_q, valid_d;
  logic             and_zero_q, and_zero_d;
  logic             parity_q, parity_d;

  // Next state: load fresh results only when in_valid qualifies the operands,
  // otherwise hold so unknown operands on idle cycles never reach the flops.
  always_comb begin
    and_d      = and_q;
    or_d       = or_q;
    xor_d      = xor_q;
    and_zero_d = and_zero_q;
    parity_d   = parity_q;
    valid_d    = in_valid;
    if (in_valid) begin
      and_d      = a & b;
      or_d       = a | b;
      xor_d      = a ^ b;
      and_zero_d = ~|(a & b);
      parity_d   = ^(a ^ b);
    end
  end

  // Result registers; reset leaves and_zero set to agree with the zeroed AND result.
  always_ff @(posedge clk) begin
    if (rst) begin
      and_q      <= '0;
      or_q       <= '0;
      xor_q      <= '0;
      valid_q    <= 1'b0;
      and_zero_q <= 1'b1;
      parity_q   <= 1'b0;
    end else begin
      and_q      <= and_d;
      or_q       <= or_d;
      xor_q      <= xor_d;
      valid_q    <= valid_d;
      and_zero_q <= and_zero_d;
      parity_q   <= parity_d;
    end
  end

  assign bitwise_and = and_q;
  assign bitwise_or  = or_q;
  assign bitwise_xor = xor_q;
  assign out_valid   = valid_q;
  assign and_zero    = and_zero_q;
  assign xor_parity  = parity_q;

endmodule

// File: tb/tb_bitwise_gates.sv
// tb/tb_bitwise_gates.sv - directed self-checking bench for bitwise_gates
module tb_bitwise_gates;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] bitwise_and;
  logic [3:0] bitwise_or;
  logic [3:0] bitwise_xor;
  logic       out_valid;
  logic       and_zero;
  logic       xor_parity;

  int n_checks = 0;
  int n_pass   = 0;

  bitwise_gates #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .bitwise_and(bitwise_and),
    .bitwise_or (bitwise_or),
    .bitwise_xor(bitwise_xor),
    .out_valid  (out_valid),
    .and_zero   (and_zero),
    .xor_parity (xor_parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_and, input logic [3:0] e_or,
                           input logic [3:0] e_xor, input logic e_v, input logic e_z,
                           input logic e_p);
    check({tag, ".and"},    {28'd0, bitwise_and}, {28'd0, e_and});
    check({tag, ".or"},     {28'd0, bitwise_or},  {28'd0, e_or});
    check({tag, ".xor"},    {28'd0, bitwise_xor}, {28'd0, e_xor});
    check({tag, ".valid"},  {31'd0, out_valid},   {31'd0, e_v});
    check({tag, ".zero"},   {31'd0, and_zero},    {31'd0, e_z});
    check({tag, ".parity"}, {31'd0, xor_parity},  {31'd0, e_p});
  endtask

  // Apply inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic v, input logic [3:0] av, input logic [3:0] bv);
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; a = 4'h0; b = 4'h0;
    @(negedge clk);

    // Reset overrides in_valid
    step(1'b1, 1'b1, 4'hF, 4'hF);
    step(1'b1, 1'b1, 4'hF, 4'hF);
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Basic
    step(1'b0, 1'b1, 4'b1100, 4'b1010);
    check_all("basic", 4'b1000, 4'b1110, 4'b0110, 1'b1, 1'b0, 1'b0);

    // Hold with in_valid low
    step(1'b0, 1'b0, 4'b0101, 4'b0011);
    check_all("hold", 4'b1000, 4'b1110, 4'b0110, 1'b0, 1'b0, 1'b0);

    // Unknown operands while idle must not disturb the held results
    step(1'b0, 1'b0, 4'bxxxx, 4'bxxxx);
    check_all("hold_x", 4'b1000, 4'b1110, 4'b0110, 1'b0, 1'b0, 1'b0);

    // Extremes
    step(1'b0, 1'b1, 4'b0000, 4'b1111);
    check_all("ext0", 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b1111);
    check_all("ext1", 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);

    // Parity
    step(1'b0, 1'b1, 4'b0001, 4'b0000);
    check_all("parity", 4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b0111, 4'b0100);
    check_all("parity3", 4'b0100, 4'b0111, 4'b0011, 1'b1, 1'b0, 1'b0);

    // Streaming random, back-to-back
    for (int i = 0; i < 8; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      step(1'b0, 1'b1, ra, rb);
      check_all($sformatf("stream%0d", i), ra & rb, ra | rb, ra ^ rb, 1'b1,
                (ra & rb) == 4'b0000, ^(ra ^ rb));
    end

    // Reset mid-stream, then first pair after release is captured
    step(1'b1, 1'b1, 4'b1011, 4'b1110);
    check_all("midrst", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0110, 4'b0011);
    check_all("postrst", 4'b0010, 4'b0111, 4'b0101, 1'b1, 1'b0, 1'b0);

    step(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_all("idle", 4'b0010, 4'b0111, 4'b0101, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
